// File: rtl/aes128_dec_key_schedule.sv
// Iterative AES-128 round-key generator for the decryption path: expands forward
// to round key 10 after a load, then steps backward one key per NEXT command.
module aes128_dec_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ctrl,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        READY  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_LOAD   = 2'b01,
        CMD_NEXT   = 2'b10,
        CMD_REWIND = 2'b11
    } cmd_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 sits in the top byte of the table, so index from the top down.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] k10_q, k10_d;
    logic [3:0]   idx_q, idx_d;
    logic         ready_q, busy_q;

    cmd_e         cmd;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, rot, t;
    logic [3:0]   rcon_sel;
    logic [127:0] fwd_key, inv_key;

    assign cmd = cmd_e'(ctrl);
    assign {w0, w1, w2, w3} = key_q;

    // One S-box bank serves both directions: forward uses w3, inverse recovers
    // the previous w3 as n3^n2.
    assign sub_in   = (state_q == EXPAND) ? w3 : (w3 ^ w2);
    assign rcon_sel = (state_q == EXPAND) ? (idx_q + 4'd1) : idx_q;
    assign rot      = {sub_in[23:0], sub_in[31:24]};
    assign t        = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                      ^ {rcon(rcon_sel), 24'h000000};

    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        fwd_key = {n0, n1, n2, n3};
        inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        k10_d   = k10_q;
        idx_d   = idx_q;
        if (cmd == CMD_LOAD) begin
            key_d   = key_in;
            idx_d   = 4'd0;
            state_d = EXPAND;
        end else begin
            case (state_q)
                EXPAND: begin
                    key_d = fwd_key;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        k10_d   = fwd_key;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (cmd == CMD_NEXT && idx_q != 4'd0) begin
                        key_d = inv_key;
                        idx_d = idx_q - 4'd1;
                    end else if (cmd == CMD_REWIND) begin
                        key_d = k10_q;
                        idx_d = 4'd10;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            k10_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            k10_q   <= k10_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == READY);
            busy_q  <= (state_d == EXPAND);
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: doc/aes128_dec_key_schedule.md
# aes128_dec_key_schedule

- Iterative AES-128 round-key generator for the decryption path.
- Sits directly downstream of the decryption FSM controller, which drives it and consumes its round keys.
- After a key load it expands forward to round key 10, then steps backward one round key per command, giving keys in the order inverse-cipher rounds need.
- Keeps a copy of round key 10, so a new block under the same key restarts without re-expansion.

## Interface

Parameters: none (AES-128 fixed).

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ctrl  input  2  command, sampled each rising edge:
  - 2'b00 HOLD
  - 2'b01 LOAD
  - 2'b10 NEXT (step to previous round key)
  - 2'b11 REWIND (restore round key 10)
- key_in  input  128  cipher key; captured on LOAD; [127:96] = w0
- round_key  output  128  current round key; [127:96] = first word
- round_idx  output  4  index (0..10) of the key on round_key
- key_ready  output  1  high in READY: round_key is valid for round_idx
- busy  output  1  high during forward expansion

## Operation

- States:
  - IDLE (reset, no key loaded)
  - EXPAND (forward expansion)
  - READY (serving keys)
- LOAD has priority in every state:
  - round_key <= key_in, round_idx <= 0, state -> EXPAND.
  - A LOAD during EXPAND restarts expansion from the new key.
- EXPAND: one forward step per cycle, commands other than LOAD ignored.
  - t = SubWord(RotWord(w3)) ^ {Rcon[idx+1], 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - round_idx increments each step.
  - When round_idx becomes 10: store the key in the k10 register, state -> READY.
- READY, NEXT with round_idx > 0: one inverse step.
  - w3 = n3^n2, w2 = n2^n1, w1 = n1^n0
  - w0 = n0 ^ SubWord(RotWord(w3)) ^ {Rcon[round_idx], 24'h0}
  - round_idx decrements.
- READY, NEXT with round_idx = 0: ignored; key and index hold.
- READY, REWIND: round_key <= k10, round_idx <= 10; single cycle, no re-expansion.
- IDLE: NEXT and REWIND ignored.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Both directions share one set of four forward S-boxes, muxed on the word fed to SubWord.
  - Unused ctrl paths must not glitch round_key.
- Reset (async, any state including mid-expansion):
  - state IDLE
  - round_key, k10 = 0
  - round_idx = 0
  - key_ready = 0, busy = 0

## Timing

- All outputs are registered; no combinational input-to-output path.
- LOAD sampled at edge T:
  - After T: busy = 1, round_idx = 0, round_key = key_in.
  - Edges T+1..T+10 produce keys 1..10.
  - After T+10: round_idx = 10, busy = 0, key_ready = 1.
- Load-to-first-decryption-key latency: 10 cycles after the LOAD edge.
- NEXT sampled in READY at edge E: previous key and index visible after E.
  - One key per cycle with NEXT held high.
  - Index 10 to 0 takes 10 consecutive NEXT cycles.
- REWIND: key 10 visible the cycle after the sampling edge.
- key_ready stays 1 throughout READY, including while stepping; drops to 0 in the cycle after a LOAD edge.
- Reset deassertion: first command accepted at the first rising edge with rst low.

## Test plan

- Reset mid-EXPAND (assert rst at expansion step 5):
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - State is IDLE after release.
  - A NEXT afterwards is ignored.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, LOAD:
  - Cycle 1: round_key = a0fafe1788542cb123a339392a6c7605, round_idx = 1.
  - 10 cycles after LOAD: round_key = d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready = 1, busy = 0.
- From READY, NEXT 10 times:
  - After the first NEXT: ac7766f319fadc2128d12941575c006e, index 9.
  - After the tenth: 2b7e151628aed2a6abf7158809cf4f3c, index 0.
  - An 11th NEXT leaves key and index 0 unchanged.
- After stepping to index 3, REWIND:
  - Next cycle: index 10, key d014f9a8….
  - A full NEXT sweep then reproduces the same sequence as the first sweep.
- NEXT and REWIND issued during EXPAND:
  - Both ignored; expansion completes on schedule.
  - A LOAD of a new key at expansion step 4 restarts: key_ready rises 10 cycles after the second LOAD.
- ctrl held at HOLD in READY for 20 cycles:
  - round_key and round_idx stable.
  - key_ready stays 1.
